// File: rtl/simd_mac_pkg.sv
// rtl/simd_mac_pkg.sv - shared constants and helpers for the SIMD multiply-accumulate pipe
//
// Purpose : per-beat mode encodings, the per-lane operation decoded by the top
//           level, and the default accumulator-width helper.
// Ports   : none (package).
// Config  : SIMD_MAC_SAT_EN is consumed by simd_mac_lane, not by this package.

package simd_mac_pkg;

    localparam logic [1:0] MODE_MUL = 2'b00;
    localparam logic [1:0] MODE_ACC = 2'b01;
    localparam logic [1:0] MODE_DOT = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    // What a single lane does when a beat moves from stage 1 into stage 2.
    typedef enum logic [1:0] {
        LOP_PASS = 2'b00,   // output the product, accumulator untouched
        LOP_ADD  = 2'b01,   // acc += addend, output the new accumulator
        LOP_ZERO = 2'b10,   // output zero, accumulator untouched
        LOP_CLR  = 2'b11    // acc = 0, output zero
    } lane_op_t;

    // Wide enough to hold the sum of LANES full-range products without wrap.
    function automatic int default_acc_w(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

endpackage

// File: rtl/simd_mac_lane.sv
// rtl/simd_mac_lane.sv - one SIMD MAC lane: product register, accumulator, saturating adder
//
// Purpose : stage-1 signed product register and stage-2 accumulate/output
//           register for a single lane.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           i_accept        - input beat accepted, capture the product
//           i_load          - stage-1 beat moves into stage 2, apply i_op
//           i_a, i_b        - signed operands
//           i_op            - lane operation for the beat in stage 1
//           i_addend        - value added to the accumulator for LOP_ADD
//           o_prod          - stage-1 product sign-extended to ACC_W
//           o_dout, o_sat   - stage-2 result and clamp flag
// Config  : SIMD_MAC_SAT_EN defined -> adder clamps to the signed ACC_W range
//           and o_sat flags it; undefined -> wrap-around, o_sat always 0.

module simd_mac_lane
    import simd_mac_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_accept,
    input  logic                    i_load,
    input  logic signed [DW-1:0]    i_a,
    input  logic signed [DW-1:0]    i_b,
    input  lane_op_t                i_op,
    input  logic [ACC_W-1:0]        i_addend,
    output logic [ACC_W-1:0]        o_prod,
    output logic [ACC_W-1:0]        o_dout,
    output logic                    o_sat
);

    logic signed [2*DW-1:0] r_prod;
    logic [ACC_W-1:0]       r_acc;
    logic [ACC_W-1:0]       r_dout;
    logic                   r_sat;
    logic [ACC_W-1:0]       w_sum;
    logic                   w_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else if (i_accept) begin
            r_prod <= (2*DW)'(i_a) * (2*DW)'(i_b);
        end
    end

    assign o_prod = ACC_W'(r_prod);

`ifdef SIMD_MAC_SAT_EN
    logic [ACC_W:0] w_sum_x;

    // One guard bit: overflow when the guard bit disagrees with the sign bit.
    always_comb begin
        w_sum_x = {r_acc[ACC_W-1], r_acc} + {i_addend[ACC_W-1], i_addend};
        w_ovf   = w_sum_x[ACC_W] ^ w_sum_x[ACC_W-1];
        if (!w_ovf) begin
            w_sum = w_sum_x[ACC_W-1:0];
        end else if (w_sum_x[ACC_W]) begin
            w_sum = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            w_sum = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_sum = r_acc + i_addend;
    assign w_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_dout <= '0;
            r_sat  <= 1'b0;
        end else if (i_load) begin
            case (i_op)
                LOP_PASS: begin
                    r_dout <= o_prod;
                    r_sat  <= 1'b0;
                end
                LOP_ADD: begin
                    r_acc  <= w_sum;
                    r_dout <= w_sum;
                    r_sat  <= w_ovf;
                end
                LOP_ZERO: begin
                    r_dout <= '0;
                    r_sat  <= 1'b0;
                end
                default: begin
                    r_acc  <= '0;
                    r_dout <= '0;
                    r_sat  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dout = r_dout;
    assign o_sat  = r_sat;

endmodule

// File: rtl/simd_mac_pipe.sv
// rtl/simd_mac_pipe.sv - two-stage handshaked SIMD multiply-accumulate array
//
// Purpose : LANES signed multiplies per beat (stage 1), then per-lane
//           accumulate, cross-lane dot-product into lane 0, pass-through or
//           clear (stage 2). Non-skid valid/ready on both sides.
// Ports   : clk, rst             - clock, synchronous active-high reset
//           mode                 - MODE_MUL/ACC/DOT/CLR, sampled with the beat
//           in_valid, in_ready   - input handshake
//           din_a, din_b         - LANES x DW signed operands
//           out_valid, out_ready - output handshake
//           dout                 - LANES x ACC_W results
//           sat                  - some lane clamped on this result beat
// Config  : SIMD_MAC_SAT_EN enables saturating ACC/DOT arithmetic.

module simd_mac_pipe
    import simd_mac_pkg::*;
#(
    parameter int LANES = 32,
    parameter int DW    = 8,
    parameter int ACC_W = default_acc_w(DW, LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DW-1:0]     din_a,
    input  logic [LANES*DW-1:0]     din_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*ACC_W-1:0]  dout,
    output logic                    sat
);

    logic             r_s1_valid;
    logic             r_s2_valid;
    logic [1:0]       r_s1_mode;
    logic             w_accept;
    logic             w_s1_move;
    logic [ACC_W-1:0] w_prod [LANES];
    logic [ACC_W-1:0] w_dot_sum;
    logic [LANES-1:0] w_lane_sat;

    // Stage 2 can take a beat when it is empty or its beat is leaving now.
    assign w_s1_move = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !rst && (!r_s1_valid || !r_s2_valid || out_ready);
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_mode  <= MODE_MUL;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_mode  <= mode;
            end else if (w_s1_move) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_move) begin
                r_s2_valid <= 1'b1;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Dot-product sum at ACC_W width; partial sums wrap, the single add into
    // lane 0's accumulator is where clamping happens.
    always_comb begin
        w_dot_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_dot_sum = w_dot_sum + w_prod[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        lane_op_t         w_op;
        logic [ACC_W-1:0] w_addend;

        always_comb begin
            w_op     = LOP_PASS;
            w_addend = w_prod[g];
            case (r_s1_mode)
                MODE_MUL: w_op = LOP_PASS;
                MODE_ACC: w_op = LOP_ADD;
                MODE_DOT: begin
                    if (g == 0) begin
                        w_op     = LOP_ADD;
                        w_addend = w_dot_sum;
                    end else begin
                        w_op = LOP_ZERO;
                    end
                end
                default:  w_op = LOP_CLR;
            endcase
        end

        simd_mac_lane #(
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_accept (w_accept),
            .i_load   (w_s1_move),
            .i_a      (din_a[g*DW +: DW]),
            .i_b      (din_b[g*DW +: DW]),
            .i_op     (w_op),
            .i_addend (w_addend),
            .o_prod   (w_prod[g]),
            .o_dout   (dout[g*ACC_W +: ACC_W]),
            .o_sat    (w_lane_sat[g])
        );
    end

    assign out_valid = r_s2_valid;
    assign sat       = |w_lane_sat;

endmodule

// File: tb/tb_simd_mac_pipe.sv
// tb/tb_simd_mac_pipe.sv - scoreboard bench for simd_mac_pipe (LANES=4, DW=8, ACC_W=16)

module tb_simd_mac_pipe;
    import simd_mac_pkg::*;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 16;

    typedef struct packed {
        logic [LANES*ACC_W-1:0] d;
        logic                   s;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             mode;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*DW-1:0]    din_a;
    logic [LANES*DW-1:0]    din_b;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] dout;
    logic                   sat;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    simd_mac_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din_a     (din_a),
        .din_b     (din_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] v4(input int x0, input int x1, input int x2, input int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    function automatic logic [63:0] e4(input int x0, input int x1, input int x2, input int x3);
        return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] e, input logic es = 1'b0, input bit push = 1'b1);
        int n = 0;
        @(negedge clk);
        mode = m; din_a = a; din_b = b; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end else if (push) begin
            sb_q.push_back('{d: e, s: es});
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk); #3; n++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Monitor: sample mid-low-phase, after the driver has settled its inputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!rst && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat dout=%h required=none", dout);
                end else begin
                    e = sb_q.pop_front();
                    chk("dout", dout, e.d);
                    chk("sat", {63'd0, sat}, {63'd0, e.s});
                end
            end
        end
    end

    initial begin
        int acc_cnt;
        int k;
        rst = 1'b1; mode = MODE_MUL; in_valid = 1'b0; out_ready = 1'b1;
        din_a = '0; din_b = '0;

        chk("default_acc_w", 64'(default_acc_w(8, 4)), 64'd18);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_dout", dout, 64'd0);
        chk("rst_sat", {63'd0, sat}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // MUL with latency check, then ACC of zero shows accumulators still 0.
        send(MODE_MUL, v4(3, -2, 127, -128), v4(5, 7, 127, -128), e4(15, -14, 16129, 16384));
        idle();
        #1;
        chk("mul_lat_n1", {63'd0, out_valid}, 64'd0);
        @(negedge clk); #1;
        chk("mul_lat_n2", {63'd0, out_valid}, 64'd1);
        send(MODE_ACC, v4(0, 0, 0, 0), v4(0, 0, 0, 0), e4(0, 0, 0, 0));
        idle();
        wait_drain();

        // Per-lane accumulation on back-to-back beats.
        send(MODE_CLR, v4(9, 9, 9, 9), v4(9, 9, 9, 9), e4(0, 0, 0, 0));
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(6, 6, 6, 6));
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(12, 12, 12, 12));
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(18, 18, 18, 18));
        idle();
        wait_drain();

        // DOT into lane 0; lanes 1..3 keep their accumulators.
        send(MODE_CLR, v4(0, 0, 0, 0), v4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(MODE_ACC, v4(0, 2, 2, 2), v4(0, 3, 3, 3), e4(0, 6, 6, 6));
        send(MODE_DOT, v4(1, 2, 3, 4), v4(1, 1, 1, 1), e4(10, 0, 0, 0));
        send(MODE_DOT, v4(1, 2, 3, 4), v4(1, 1, 1, 1), e4(20, 0, 0, 0));
        send(MODE_ACC, v4(0, 0, 0, 0), v4(0, 0, 0, 0), e4(20, 6, 6, 6));
        idle();
        wait_drain();

        // Backpressure: only two beats fit while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0;
        acc_cnt = 0;
        k = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            mode = MODE_MUL; din_a = v4(k+1, k+1, k+1, k+1); din_b = v4(3, 3, 3, 3);
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                sb_q.push_back('{d: e4(3*(k+1), 3*(k+1), 3*(k+1), 3*(k+1)), s: 1'b0});
                k++;
                acc_cnt++;
            end
        end
        @(negedge clk); #1;
        chk("bp_accepts", 64'(acc_cnt), 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_dout_hold", dout, e4(3, 3, 3, 3));
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int j = 2; j < 4; j++) begin
            send(MODE_MUL, v4(j+1, j+1, j+1, j+1), v4(3, 3, 3, 3),
                 e4(3*(j+1), 3*(j+1), 3*(j+1), 3*(j+1)));
        end
        idle();
        wait_drain();

        // Saturation vs wrap at ACC_W=16.
        send(MODE_CLR, v4(0, 0, 0, 0), v4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(MODE_ACC, v4(127, 127, 127, 127), v4(127, 127, 127, 127), e4(16129, 16129, 16129, 16129));
        send(MODE_ACC, v4(127, 127, 127, 127), v4(127, 127, 127, 127), e4(32258, 32258, 32258, 32258));
`ifdef SIMD_MAC_SAT_EN
        send(MODE_ACC, v4(127, 127, 127, 127), v4(127, 127, 127, 127), e4(32767, 32767, 32767, 32767), 1'b1);
`else
        send(MODE_ACC, v4(127, 127, 127, 127), v4(127, 127, 127, 127), e4(-17149, -17149, -17149, -17149), 1'b0);
`endif
        idle();
        wait_drain();

        // Reset with a beat in flight: it must vanish and accumulators clear.
        send(MODE_CLR, v4(0, 0, 0, 0), v4(0, 0, 0, 0), e4(0, 0, 0, 0));
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(6, 6, 6, 6));
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(12, 12, 12, 12));
        idle();
        wait_drain();
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(0, 0, 0, 0), 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk); #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_release", {63'd0, in_ready}, 64'd1);
        send(MODE_ACC, v4(2, 2, 2, 2), v4(3, 3, 3, 3), e4(6, 6, 6, 6));
        idle();
        wait_drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
